// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship gunner slice.
//   DIR_T/B/L/R     aim direction codes (00=T 01=B 10=L 11=R)
//   gunner_state_e  one-hot gunner FSM encoding
//   dir_from_btn    resolves a direction button vector to a code, lowest index wins
package nexys_starship_pkg;

  localparam logic [1:0] DIR_T = 2'b00;
  localparam logic [1:0] DIR_B = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_R = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ARMED    = 4'b0010,
    ST_COOLDOWN = 4'b0100,
    ST_OVER     = 4'b1000
  } gunner_state_e;

  // btn bit order is {R,L,B,T}; T has highest priority.
  function automatic logic [1:0] dir_from_btn(input logic [3:0] btn);
    logic [1:0] dir;
    if (btn[0])      dir = DIR_T;
    else if (btn[1]) dir = DIR_B;
    else if (btn[2]) dir = DIR_L;
    else             dir = DIR_R;
    return dir;
  endfunction

endpackage

// File: rtl/nexys_starship_tick_counter.sv
// Down-counter of game-timer ticks with a terminal-count pulse.
//   Clk, Reset   system clock, synchronous active-high reset
//   clear        force the count to zero (highest priority after Reset)
//   load         start a new interval of load_val ticks; a tick in the
//                load cycle is not counted
//   tick         one-cycle timer pulse
//   done         one-cycle pulse on the tick that ends the interval
module nexys_starship_tick_counter #(
  parameter int unsigned W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      done  = (cnt_q == W'(1));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nexys_starship_gunner.sv
// Player-side gunner controller for the four monster terminals {R,L,B,T}.
// Aims, fires, writes monster state back to the terminals, broadcasts
// gameover and keeps the score.
//   Clk, Reset       system clock, synchronous active-high reset
//   timer_tick       one-cycle game-timer pulse
//   play_flag        game running
//   btn_dir, btn_fire  debounced one-cycle button pulses
//   monster_sm       per-terminal monster present
//   gameover_sm      per-terminal gameover
//   monster_ctrl     per-terminal monster write-back (registered)
//   gameover_ctrl    global gameover broadcast (registered)
//   aim_dir          current aim, 00=T 01=B 10=L 11=R
//   score            kills this game, saturating
//   ammo             remaining shots (GUNNER_AMMO_EN builds only)
//   ready            a shot would be accepted this cycle
// Build option: define GUNNER_AMMO_EN for a finite magazine with timed reload.
//
// state    | meaning
// IDLE     | no game; waits for play_flag
// ARMED    | game running, a shot may be taken
// COOLDOWN | shot taken, waiting COOLDOWN_TICKS timer ticks
// OVER     | a terminal reported gameover; waits for play_flag low
module nexys_starship_gunner
  import nexys_starship_pkg::*;
#(
  parameter int unsigned COOLDOWN_TICKS = 3,
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned AMMO_MAX       = 4,
  parameter int unsigned RELOAD_TICKS   = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           timer_tick,
  input  logic                           play_flag,
  input  logic [3:0]                     btn_dir,
  input  logic                           btn_fire,
  input  logic [3:0]                     monster_sm,
  input  logic [3:0]                     gameover_sm,
  output logic [3:0]                     monster_ctrl,
  output logic                           gameover_ctrl,
  output logic [1:0]                     aim_dir,
  output logic [SCORE_W-1:0]             score,
`ifdef GUNNER_AMMO_EN
  output logic [$clog2(AMMO_MAX+1)-1:0]  ammo,
`endif
  output logic                           ready
);

  localparam int unsigned CW = $clog2(COOLDOWN_TICKS + 1);

  if (COOLDOWN_TICKS < 1 || AMMO_MAX < 1 || RELOAD_TICKS < 1) begin : g_bad_cfg
    $error("nexys_starship_gunner: tick and ammo parameters must be at least 1");
  end

  gunner_state_e      state_q, state_d;
  logic [1:0]         aim_dir_q, aim_dir_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         kill_hold_q, kill_hold_d;
  logic [3:0]         monster_ctrl_q, monster_ctrl_d;
  logic               gameover_ctrl_q, gameover_ctrl_d;

  logic       go_any, start, shot, hit, cool_done, ammo_ok, ready_c;
  logic [3:0] hit_vec;

  assign go_any  = |gameover_sm;
  assign start   = (state_q == ST_IDLE) && play_flag;
  assign ready_c = (state_q == ST_ARMED) && ammo_ok;
  // A shot in the same cycle as gameover is dropped: the game is over.
  assign shot    = btn_fire && ready_c && !go_any;
  assign hit     = shot && monster_sm[aim_dir_q];

  always_comb begin
    hit_vec = 4'b0000;
    if (hit) hit_vec[aim_dir_q] = 1'b1;
  end

  nexys_starship_tick_counter #(.W(CW)) u_cooldown (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (start),
    .load     (shot),
    .load_val (CW'(COOLDOWN_TICKS)),
    .tick     (timer_tick),
    .done     (cool_done)
  );

`ifdef GUNNER_AMMO_EN
  localparam int unsigned AW = $clog2(AMMO_MAX + 1);
  localparam int unsigned RW = $clog2(RELOAD_TICKS + 1);

  logic [AW-1:0] ammo_q, ammo_d;
  logic          reload_done;

  // The shot that empties the magazine starts the reload interval.
  nexys_starship_tick_counter #(.W(RW)) u_reload (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (start),
    .load     (shot && (ammo_q == AW'(1))),
    .load_val (RW'(RELOAD_TICKS)),
    .tick     (timer_tick),
    .done     (reload_done)
  );

  always_comb begin
    ammo_d = ammo_q;
    if (start || reload_done) ammo_d = AW'(AMMO_MAX);
    else if (shot)            ammo_d = ammo_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) ammo_q <= '0;
    else       ammo_q <= ammo_d;
  end

  assign ammo_ok = (ammo_q != '0);
  assign ammo    = ammo_q;
`else
  assign ammo_ok = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    aim_dir_d       = aim_dir_q;
    score_d         = score_q;
    kill_hold_d     = kill_hold_q;
    monster_ctrl_d  = monster_ctrl_q;
    gameover_ctrl_d = gameover_ctrl_q;

    case (state_q)
      ST_IDLE:     if (play_flag) state_d = ST_ARMED;
      ST_ARMED:    if (go_any) state_d = ST_OVER;
                   else if (shot) state_d = ST_COOLDOWN;
      ST_COOLDOWN: if (go_any) state_d = ST_OVER;
                   else if (cool_done) state_d = ST_ARMED;
      ST_OVER:     if (!play_flag) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (((state_q == ST_ARMED) || (state_q == ST_COOLDOWN)) && (btn_dir != 4'b0000))
      aim_dir_d = dir_from_btn(btn_dir);

    if (start)                 score_d = '0;
    else if (hit && !(&score_q)) score_d = score_q + 1'b1;

    // A killed monster stays suppressed until its terminal acknowledges by
    // dropping monster_sm; afterwards the terminal's own state is echoed.
    if (start) kill_hold_d = 4'b0000;
    else       kill_hold_d = hit_vec | (kill_hold_q & monster_sm);

    if (state_d == ST_OVER) monster_ctrl_d = 4'b0000;
    else                    monster_ctrl_d = monster_sm & ~(kill_hold_q | hit_vec);

    gameover_ctrl_d = (state_d != ST_IDLE) && (go_any || (state_d == ST_OVER));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      aim_dir_q       <= DIR_T;
      score_q         <= '0;
      kill_hold_q     <= 4'b0000;
      monster_ctrl_q  <= 4'b0000;
      gameover_ctrl_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      aim_dir_q       <= aim_dir_d;
      score_q         <= score_d;
      kill_hold_q     <= kill_hold_d;
      monster_ctrl_q  <= monster_ctrl_d;
      gameover_ctrl_q <= gameover_ctrl_d;
    end
  end

  assign monster_ctrl  = monster_ctrl_q;
  assign gameover_ctrl = gameover_ctrl_q;
  assign aim_dir       = aim_dir_q;
  assign score         = score_q;
  assign ready         = ready_c;

endmodule

// File: tb/tb_nexys_starship_gunner.sv
module tb_nexys_starship_gunner;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       timer_tick = 1'b0;
  logic       play_flag = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic       btn_fire = 1'b0;
  logic [3:0] monster_sm = 4'b0000;
  logic [3:0] gameover_sm = 4'b0000;
  logic [3:0] monster_ctrl;
  logic       gameover_ctrl;
  logic [1:0] aim_dir;
  logic [7:0] score;
  logic       ready;
`ifdef GUNNER_AMMO_EN
  logic [2:0] ammo;
`endif

  int vectors = 0;
  int miscompares = 0;
  int m_score = 0;

  typedef struct {
    string      tag;
    logic [7:0] score;
    logic [3:0] mctrl;
  } exp_t;
  exp_t sb[$];

  nexys_starship_gunner dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .timer_tick    (timer_tick),
    .play_flag     (play_flag),
    .btn_dir       (btn_dir),
    .btn_fire      (btn_fire),
    .monster_sm    (monster_sm),
    .gameover_sm   (gameover_sm),
    .monster_ctrl  (monster_ctrl),
    .gameover_ctrl (gameover_ctrl),
    .aim_dir       (aim_dir),
    .score         (score),
`ifdef GUNNER_AMMO_EN
    .ammo          (ammo),
`endif
    .ready         (ready)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      timer_tick = 1'b1;
      cycle();
      timer_tick = 1'b0;
      cycle();
    end
  endtask

  // Drive one fire pulse and record the expected post-shot outputs.
  task automatic fire(input string tag, input logic [7:0] exp_score, input logic [3:0] exp_mctrl);
    exp_t e;
    e.tag = tag; e.score = exp_score; e.mctrl = exp_mctrl;
    sb.push_back(e);
    btn_fire = 1'b1;
    cycle();
    btn_fire = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cycle(); cycle();
    vectors++; if (monster_ctrl !== 4'b0000) begin miscompares++; $display("FAIL reset_mctrl got %b want 0000", monster_ctrl); end
    vectors++; if (gameover_ctrl !== 1'b0) begin miscompares++; $display("FAIL reset_goctrl got %b want 0", gameover_ctrl); end
    vectors++; if (aim_dir !== 2'b00) begin miscompares++; $display("FAIL reset_aim got %b want 00", aim_dir); end
    vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL reset_score got %0d want 0", score); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
    Reset = 1'b0;
    cycle();
  endtask

  task automatic test_start();
    play_flag = 1'b1;
    cycle();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL start_ready got %b want 1", ready); end
    vectors++; if (aim_dir !== 2'b00) begin miscompares++; $display("FAIL start_aim got %b want 00", aim_dir); end
    vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL start_score got %0d want 0", score); end
  endtask

  task automatic test_hit();
    exp_t e;
    monster_sm = 4'b0010;
    cycle();
    vectors++; if (monster_ctrl !== 4'b0010) begin miscompares++; $display("FAIL hit_echo got %b want 0010", monster_ctrl); end
    btn_dir = 4'b0010;
    cycle();
    btn_dir = 4'b0000;
    vectors++; if (aim_dir !== 2'b01) begin miscompares++; $display("FAIL hit_aim got %b want 01", aim_dir); end
    m_score++;
    fire("hit_b", 8'(m_score), 4'b0000);
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL hit_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (score !== e.score) begin miscompares++; $display("FAIL %s score got %0d want %0d", e.tag, score, e.score); end
      vectors++; if (monster_ctrl !== e.mctrl) begin miscompares++; $display("FAIL %s mctrl got %b want %b", e.tag, monster_ctrl, e.mctrl); end
    end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL hit_ready0 got %b want 0", ready); end
    for (int t = 1; t <= 3; t++) begin
      tick(1);
      vectors++;
      if (ready !== (t == 3)) begin miscompares++; $display("FAIL hit_cool_t%0d ready got %b want %b", t, ready, (t == 3)); end
    end
    vectors++; if (monster_ctrl !== 4'b0000) begin miscompares++; $display("FAIL hit_hold got %b want 0000", monster_ctrl); end
    monster_sm = 4'b0000;
    cycle();
    monster_sm = 4'b0010;
    cycle();
    vectors++; if (monster_ctrl !== 4'b0010) begin miscompares++; $display("FAIL hit_respawn got %b want 0010", monster_ctrl); end
  endtask

  task automatic test_fire_spam();
    exp_t e;
    m_score++;
    e.tag = "spam_first"; e.score = 8'(m_score); e.mctrl = 4'b0000;
    sb.push_back(e);
    btn_fire = 1'b1;
    cycle();
    e = sb.pop_front();
    vectors++; if (score !== e.score) begin miscompares++; $display("FAIL %s score got %0d want %0d", e.tag, score, e.score); end
    vectors++; if (monster_ctrl !== e.mctrl) begin miscompares++; $display("FAIL %s mctrl got %b want %b", e.tag, monster_ctrl, e.mctrl); end
    tick(2);
    timer_tick = 1'b1;
    cycle();
    timer_tick = 1'b0;
    btn_fire = 1'b0;
    vectors++; if (score !== 8'(m_score)) begin miscompares++; $display("FAIL spam_score got %0d want %0d", score, m_score); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL spam_ready got %b want 1", ready); end
    monster_sm = 4'b0000;
    cycle();
  endtask

  task automatic test_same_cycle_dir();
    exp_t e;
    btn_dir = 4'b0001;
    monster_sm = 4'b0001;
    cycle();
    btn_dir = 4'b0100;
    m_score++;
    fire("same_cycle_t", 8'(m_score), 4'b0000);
    btn_dir = 4'b0000;
    vectors++; if (aim_dir !== 2'b10) begin miscompares++; $display("FAIL same_aim got %b want 10", aim_dir); end
    e = sb.pop_front();
    vectors++; if (score !== e.score) begin miscompares++; $display("FAIL %s score got %0d want %0d", e.tag, score, e.score); end
    vectors++; if (monster_ctrl !== e.mctrl) begin miscompares++; $display("FAIL %s mctrl got %b want %b", e.tag, monster_ctrl, e.mctrl); end
    tick(3);
    monster_sm = 4'b0000;
    cycle();
  endtask

  task automatic test_dir_priority_miss();
    exp_t e;
    logic [3:0] pats [3] = '{4'b1111, 4'b1100, 4'b1000};
    logic [1:0] want [3] = '{2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      btn_dir = pats[i];
      cycle();
      btn_dir = 4'b0000;
      vectors++; if (aim_dir !== want[i]) begin miscompares++; $display("FAIL prio_%b got %b want %b", pats[i], aim_dir, want[i]); end
    end
    fire("miss_r", 8'(m_score), 4'b0000);
    e = sb.pop_front();
    vectors++; if (score !== e.score) begin miscompares++; $display("FAIL %s score got %0d want %0d", e.tag, score, e.score); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL miss_ready got %b want 0", ready); end
    btn_dir = 4'b1010;
    cycle();
    btn_dir = 4'b0000;
    vectors++; if (aim_dir !== 2'b01) begin miscompares++; $display("FAIL cool_aim got %b want 01", aim_dir); end
    tick(3);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL miss_rearm got %b want 1", ready); end
  endtask

  task automatic test_gameover();
    monster_sm = 4'b0100;
    cycle();
    fire("go_miss", 8'(m_score), 4'b0100);
    void'(sb.pop_front());
    vectors++; if (monster_ctrl !== 4'b0100) begin miscompares++; $display("FAIL go_echo got %b want 0100", monster_ctrl); end
    gameover_sm = 4'b1000;
    cycle();
    gameover_sm = 4'b0000;
    vectors++; if (gameover_ctrl !== 1'b1) begin miscompares++; $display("FAIL go_ctrl got %b want 1", gameover_ctrl); end
    vectors++; if (monster_ctrl !== 4'b0000) begin miscompares++; $display("FAIL go_mctrl got %b want 0000", monster_ctrl); end
    btn_fire = 1'b1;
    btn_dir = 4'b0001;
    monster_sm = 4'b0010;
    cycle();
    btn_fire = 1'b0;
    btn_dir = 4'b0000;
    vectors++; if (gameover_ctrl !== 1'b1) begin miscompares++; $display("FAIL over_hold got %b want 1", gameover_ctrl); end
    vectors++; if (score !== 8'(m_score)) begin miscompares++; $display("FAIL over_score got %0d want %0d", score, m_score); end
    vectors++; if (aim_dir !== 2'b01) begin miscompares++; $display("FAIL over_aim got %b want 01", aim_dir); end
    vectors++; if (monster_ctrl !== 4'b0000) begin miscompares++; $display("FAIL over_mctrl got %b want 0000", monster_ctrl); end
    play_flag = 1'b0;
    monster_sm = 4'b0000;
    cycle();
    vectors++; if (gameover_ctrl !== 1'b0) begin miscompares++; $display("FAIL idle_goctrl got %b want 0", gameover_ctrl); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got %b want 0", ready); end
    btn_dir = 4'b0100;
    cycle();
    btn_dir = 4'b0000;
    vectors++; if (aim_dir !== 2'b01) begin miscompares++; $display("FAIL idle_aim got %b want 01", aim_dir); end
    play_flag = 1'b1;
    m_score = 0;
    cycle();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL restart_ready got %b want 1", ready); end
    vectors++; if (score !== 8'(m_score)) begin miscompares++; $display("FAIL restart_score got %0d want 0", score); end
  endtask

`ifdef GUNNER_AMMO_EN
  task automatic test_ammo();
    vectors++; if (ammo !== 3'd4) begin miscompares++; $display("FAIL ammo_full got %0d want 4", ammo); end
    for (int i = 0; i < 4; i++) begin
      fire("ammo_shot", 8'(m_score), 4'b0000);
      void'(sb.pop_front());
      vectors++; if (ammo !== 3'(3 - i)) begin miscompares++; $display("FAIL ammo_dec%0d got %0d want %0d", i, ammo, 3 - i); end
      if (i < 3) tick(3);
    end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ammo_empty_ready got %b want 0", ready); end
    tick(3);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ammo_cool_ready got %b want 0", ready); end
    tick(4);
    vectors++; if (ammo !== 3'd0) begin miscompares++; $display("FAIL ammo_t7 got %0d want 0", ammo); end
    tick(1);
    vectors++; if (ammo !== 3'd4) begin miscompares++; $display("FAIL ammo_reload got %0d want 4", ammo); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL ammo_ready got %b want 1", ready); end
    for (int i = 0; i < 4; i++) begin
      fire("ammo_shot2", 8'(m_score), 4'b0000);
      void'(sb.pop_front());
      if (i < 3) tick(3);
    end
    tick(2);
    Reset = 1'b1;
    play_flag = 1'b0;
    cycle();
    Reset = 1'b0;
    vectors++; if (ammo !== 3'd0) begin miscompares++; $display("FAIL ammo_reset got %0d want 0", ammo); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ammo_reset_ready got %b want 0", ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_fire_spam();
    test_same_cycle_dir();
    test_dir_priority_miss();
    test_gameover();
`ifdef GUNNER_AMMO_EN
    test_ammo();
`endif
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
